mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory port (address, datao, rw, data) between two bus masters: master 0 (CPU fetch/execute) and master 1 (loader/DMA).
- Sits between the masters and the memory.
- Uses round-robin arbitration, a request/grant handshake, and fixed-latency read-data return.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from address issue to valid read data on mem_data (legal range 1..15).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- m0_req  in  1  master 0 request; held until m0_gnt
- m0_rw  in  1  master 0 direction, 1=write, 0=read
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  one-cycle pulse: request accepted
- m0_rdata  out  DATA_W  master 0 read data
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m1_req, m1_rw, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid  same as m0_* for master 1
- mem_address  out  ADDR_W  memory address
- mem_datao  out  DATA_W  memory write data
- mem_rw  out  1  memory write strobe, 1=write
- mem_en  out  1  memory access active
- mem_data  in  DATA_W  memory read data

Behaviour:
- Reset (asynchronous, active-high; clock is clock): every output is 0, state=IDLE, last_winner=1 (master 0 wins the first tie). Reset asserted mid-transaction aborts it: no gnt, no rvalid, and memory outputs go to 0 immediately.
- States: IDLE, ACCESS, WAIT.
- IDLE:
  - No req: stay in IDLE; mem_en=0, mem_rw=0.
  - Any req sampled high: choose a winner.
    - Single requester wins.
    - Both requesting: the master not equal to last_winner wins.
  - Latch the winner's rw/addr/wdata into internal registers and update last_winner.
  - Next cycle: state=ACCESS, winner's gnt=1 for exactly that cycle.
- ACCESS (1 cycle): mem_en=1, mem_address=latched addr, mem_rw=latched rw, mem_datao=latched wdata.
  - Write: the transaction completes in this cycle; next state is IDLE.
  - Read: next state is WAIT, with wait counter loaded to MEM_LAT-1.
- WAIT:
  - mem_en=1 and mem_address held; mem_rw=0.
  - Counter decrements each cycle.
  - When the counter equals 0, mem_data is captured into the owner's rdata. The owner's rvalid pulses high on the following cycle, coinciding with the return to IDLE.
- Latency:
  - Read: gnt at cycle N, rvalid at N+MEM_LAT+1.
  - Write: gnt at N, bus write at N; the earliest next gnt is N+2.
- Bus outputs are registered; no combinational path from req to mem_*.
- Request semantics:
  - req is sampled only in IDLE.
  - A master may drop req before gnt (withdrawal, no side effects).
  - req held high after gnt starts a new transaction.
  - addr/rw/wdata must be stable while req=1 before gnt; they are don't-care after gnt.
- rdata holds its last value until the next read for the same master. The other master's rdata is never modified.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1. Neither master waits more than one transaction.
- mem_address width: ADDR_W, zero-extended internally. No wrap-around arithmetic is performed.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: master 0 always wins ties; last_winner is unused. Master 1 is granted only when m0_req=0 in IDLE (starvation permitted by design).
- Undefined: round-robin as specified above.

Test Plan:
- Reset: assert reset mid-clock → all outputs 0 immediately; after release, with no req, mem_en stays 0 for 10 cycles.
- m0 read, addr 0x0000_0010, mem_data=0xDEADBEEF, MEM_LAT=1 → m0_gnt at cycle N, mem_en=1 and mem_address=0x10 at N, m0_rvalid at N+2 with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- m1 write, addr 0x20, wdata 0x12345678 → m1_gnt and mem_rw=1, mem_address=0x20, mem_datao=0x12345678 in the same cycle; no rvalid pulse.
- Both masters issue continuous reads from reset → grant order m0,m1,m0,m1. With MEM_LAT=3, successive gnts are 5 cycles apart.
- Reset asserted in WAIT of an m0 read → no m0_rvalid; after release, a new m1 request is granted normally.
- With ARB_FIXED_PRIORITY_EN, both masters requesting continuously → only m0_gnt pulses. Drop m0_req → m1_gnt on the next arbitration.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter for a single fixed-latency memory port
// Optional macro ARB_FIXED_PRIORITY_EN: master 0 always wins ties (master 1 may starve).
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req_i,
    input  logic              m0_rw_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_rvalid_o,
    input  logic              m1_req_i,
    input  logic              m1_rw_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_rvalid_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_datao_o,
    output logic              mem_rw_o,
    output logic              mem_en_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [3:0] LAT_LOAD  = 4'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              last_winner_q, last_winner_d;
    logic              owner_q, owner_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_datao_q, mem_datao_d;
    logic              mem_rw_q, mem_rw_d;
    logic              mem_en_q, mem_en_d;
    logic              m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic              winner;

    always_comb begin
`ifdef ARB_FIXED_PRIORITY_EN
        winner = ~m0_req_i;
`else
        // On a tie the master that did not win last time goes next.
        winner = (m0_req_i && m1_req_i) ? ~last_winner_q : m1_req_i;
`endif
    end

    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        mem_address_d = mem_address_q;
        mem_datao_d   = mem_datao_q;
        mem_rw_d      = mem_rw_q;
        mem_en_d      = mem_en_q;
        m0_gnt_d      = 1'b0;
        m1_gnt_d      = 1'b0;
        m0_rvalid_d   = 1'b0;
        m1_rvalid_d   = 1'b0;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;

        case (state_q)
            ST_IDLE: begin
                mem_en_d = 1'b0;
                mem_rw_d = 1'b0;
                if (m0_req_i || m1_req_i) begin
                    owner_d       = winner;
                    last_winner_d = winner;
                    mem_address_d = winner ? m1_addr_i  : m0_addr_i;
                    mem_datao_d   = winner ? m1_wdata_i : m0_wdata_i;
                    mem_rw_d      = winner ? m1_rw_i    : m0_rw_i;
                    mem_en_d      = 1'b1;
                    m0_gnt_d      = ~winner;
                    m1_gnt_d      = winner;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_rw_q) begin
                    mem_en_d = 1'b0;
                    mem_rw_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_rw_d = 1'b0;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    if (owner_q) begin
                        m1_rdata_d  = mem_data_i;
                        m1_rvalid_d = 1'b1;
                    end else begin
                        m0_rdata_d  = mem_data_i;
                        m0_rvalid_d = 1'b1;
                    end
                    mem_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                mem_en_d = 1'b0;
                mem_rw_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Asynchronous reset so an abort drops the memory strobes without waiting for a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_winner_q <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= 4'd0;
            mem_address_q <= '0;
            mem_datao_q   <= '0;
            mem_rw_q      <= 1'b0;
            mem_en_q      <= 1'b0;
            m0_gnt_q      <= 1'b0;
            m1_gnt_q      <= 1'b0;
            m0_rvalid_q   <= 1'b0;
            m1_rvalid_q   <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            mem_address_q <= mem_address_d;
            mem_datao_q   <= mem_datao_d;
            mem_rw_q      <= mem_rw_d;
            mem_en_q      <= mem_en_d;
            m0_gnt_q      <= m0_gnt_d;
            m1_gnt_q      <= m1_gnt_d;
            m0_rvalid_q   <= m0_rvalid_d;
            m1_rvalid_q   <= m1_rvalid_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
        end
    end

    assign m0_gnt_o      = m0_gnt_q;
    assign m1_gnt_o      = m1_gnt_q;
    assign m0_rvalid_o   = m0_rvalid_q;
    assign m1_rvalid_o   = m1_rvalid_q;
    assign m0_rdata_o    = m0_rdata_q;
    assign m1_rdata_o    = m1_rdata_q;
    assign mem_address_o = mem_address_q;
    assign mem_datao_o   = mem_datao_q;
    assign mem_rw_o      = mem_rw_q;
    assign mem_en_o      = mem_en_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    localparam int LAT = 3;
    localparam int M_OFF = 0, M_RAND = 1, M_CONT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req[2];
    logic        rw[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata[2];
    logic [31:0] mem_address, mem_datao, mem_data;
    logic        mem_rw, mem_en;
    int          cyc = 0;
    int          n_vec = 0, n_mis = 0;

    typedef struct {int m; logic rw; logic [31:0] addr; logic [31:0] wd; int cyc;} gnt_t;
    typedef struct {int m; logic [31:0] data; int cyc;} rd_t;
    gnt_t        gq[$];
    rd_t         rq[$];
    logic [31:0] dev_mem[16];
    logic [31:0] ref_mem[16];

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .m0_req_i(req[0]), .m0_rw_i(rw[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
        .m0_gnt_o(gnt[0]), .m0_rdata_o(rdata[0]), .m0_rvalid_o(rvalid[0]),
        .m1_req_i(req[1]), .m1_rw_i(rw[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
        .m1_gnt_o(gnt[1]), .m1_rdata_o(rdata[1]), .m1_rvalid_o(rvalid[1]),
        .mem_address_o(mem_address), .mem_datao_o(mem_datao), .mem_rw_o(mem_rw),
        .mem_en_o(mem_en), .mem_data_i(mem_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    wire any_out = |{gnt, rvalid, rdata[0], rdata[1], mem_address, mem_datao, mem_rw, mem_en};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, arbitration whenever the port is free.
    initial begin
        int   free_at;
        int   lw;
        int   w;
        gnt_t g;
        rd_t  r;
        free_at = 0;
        lw = 1;
        forever begin
            @(negedge clock);
            if (reset) begin
                lw = 1;
                free_at = cyc + 1;
                gq.delete();
                rq.delete();
            end else if (cyc >= free_at) begin
                if (req[0] || req[1]) begin
                    if (req[0] && req[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
                        w = 0;
`else
                        w = 1 - lw;
`endif
                    end else begin
                        w = req[1] ? 1 : 0;
                    end
                    g.m = w; g.rw = rw[w]; g.addr = addr[w]; g.wd = wdata[w]; g.cyc = cyc + 1;
                    gq.push_back(g);
                    if (g.rw) begin
                        ref_mem[g.addr[5:2]] = g.wd;
                        free_at = cyc + 2;
                    end else begin
                        r.m = w; r.data = ref_mem[g.addr[5:2]]; r.cyc = cyc + 2 + LAT;
                        rq.push_back(r);
                        free_at = cyc + 2 + LAT;
                    end
                    lw = w;
                end else begin
                    free_at = cyc + 1;
                end
            end
        end
    end

    // Memory device: read data is only valid exactly LAT cycles after the address issue.
    initial begin
        int          age;
        logic [31:0] raddr;
        age = -1;
        raddr = '0;
        mem_data = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                age = -1;
            end else begin
                if (mem_en && mem_rw) dev_mem[mem_address[5:2]] = mem_datao;
                if ((gnt != 2'b00) && mem_en && !mem_rw) begin
                    age = 0;
                    raddr = mem_address;
                end else if (age >= 0) begin
                    age++;
                end
            end
            mem_data = (age == LAT) ? dev_mem[raddr[5:2]] : $urandom;
        end
    end

    // Monitor: pops expectations whenever the DUT presents gnt or rvalid.
    initial begin
        int          en_until;
        logic [31:0] exp_rd[2];
        gnt_t        g;
        rd_t         r;
        en_until = -1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                en_until = -1;
                exp_rd[0] = '0;
                exp_rd[1] = '0;
            end else begin
                if (gnt != 2'b00) begin
                    chk("gnt_expected", gq.size() != 0, 1);
                    if (gq.size() != 0) begin
                        g = gq.pop_front();
                        chk("gnt_master", gnt, (g.m == 1) ? 2'b10 : 2'b01);
                        chk("gnt_cycle", cyc, g.cyc);
                        chk("acc_addr", mem_address, g.addr);
                        chk("acc_rw", mem_rw, g.rw);
                        if (g.rw) chk("acc_wdata", mem_datao, g.wd);
                        en_until = g.rw ? cyc : cyc + LAT;
                    end
                end else begin
                    chk("mem_rw_quiet", mem_rw, 0);
                end
                chk("mem_en", mem_en, cyc <= en_until);
                if (rvalid != 2'b00) begin
                    chk("rvalid_expected", rq.size() != 0, 1);
                    if (rq.size() != 0) begin
                        r = rq.pop_front();
                        chk("rvalid_master", rvalid, (r.m == 1) ? 2'b10 : 2'b01);
                        chk("rvalid_cycle", cyc, r.cyc);
                        exp_rd[r.m] = r.data;
                    end
                end
                chk("m0_rdata", rdata[0], exp_rd[0]);
                chk("m1_rdata", rdata[1], exp_rd[1]);
            end
        end
    end

    task automatic new_req(input int m, input bit rd_only);
        req[m] = 1'b1;
        rw[m] = rd_only ? 1'b0 : 1'($urandom % 2);
        addr[m] = $urandom;
        wdata[m] = $urandom;
    endtask

    task automatic step(input int mode);
        @(posedge clock);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (req[m] && gnt[m]) begin
                if (mode == M_CONT) new_req(m, 1'b1);
                else if (mode == M_RAND && ($urandom % 2) == 0) new_req(m, 1'b0);
                else req[m] = 1'b0;
            end else if (!req[m]) begin
                if (mode == M_CONT) new_req(m, 1'b1);
                else if (mode == M_RAND && ($urandom % 3) == 0) new_req(m, 1'b0);
            end else if (mode == M_RAND && ($urandom % 25) == 0) begin
                req[m] = 1'b0;
            end
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            dev_mem[i] = 32'hA5A50000 ^ (i * 32'h01010101);
            ref_mem[i] = 32'hA5A50000 ^ (i * 32'h01010101);
        end
        dev_mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        #1 chk("reset_outputs", any_out, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(M_OFF);
            chk("idle_mem_en", mem_en, 0);
        end

        req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h10; wdata[0] = 32'h0;
        repeat (10) step(M_OFF);
        req[1] = 1'b1; rw[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h12345678;
        repeat (6) step(M_OFF);

        repeat (40) step(M_CONT);
        repeat (20) step(M_OFF);
        repeat (1500) step(M_RAND);
        repeat (60) step(M_OFF);

        // Abort an m0 read while it is waiting for memory data.
        req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h34; wdata[0] = '0;
        k = 0;
        while (!gnt[0] && k < 20) begin
            step(M_OFF);
            k++;
        end
        chk("abort_gnt_seen", gnt[0], 1);
        repeat (2) step(M_OFF);
        #3 reset = 1'b1;
        #1 chk("abort_outputs", any_out, 0);
        step(M_OFF);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(M_OFF);
            chk("abort_no_rvalid", rvalid, 0);
        end
        req[1] = 1'b1; rw[1] = 1'b0; addr[1] = 32'h10; wdata[1] = '0;
        repeat (12) step(M_OFF);

        chk("gnt_queue_drained", gq.size(), 0);
        chk("rd_queue_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
